ecc_pm_job_sequencer: RTL and testbench
=======================================

Name: ecc_pm_job_sequencer

Overview:
- Synthesizable job front-end for the ECC point-multiplication core (R = k·P).
- Accepts (Px, Py, k, tag) requests over a valid/ready interface and buffers them in a DEPTH-entry FIFO.
- Issues jobs one at a time to the core using its single-cycle in_valid pulse and out_valid completion protocol.
- Returns (Rx, Ry, tag, err) on a valid/ready response port, with a watchdog that converts a hung core into an error response.

Parameters:
DATA_WIDTH, 256, coordinate/scalar width
DEPTH, 4, request FIFO entries (power of 2, ≥2)
TAG_W, 4, request tag width
TIMEOUT_CYCLES, 1000000, max WAIT cycles before error response
CNT_W, 32, watchdog/latency counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accept (= FIFO not full)
req_px / req_py / req_k  in  DATA_WIDTH each  point P and scalar k
req_tag  in  TAG_W  request tag
core_in_valid  out  1  one-cycle start pulse to core
core_px / core_py / core_k  out  DATA_WIDTH each  operands to core
core_rx / core_ry  in  DATA_WIDTH each  core result
core_out_valid  in  1  core result valid
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_rx / rsp_ry  out  DATA_WIDTH each  result coordinates
rsp_tag  out  TAG_W  tag of the completed job
rsp_err  out  1  1 = watchdog timeout, result invalid
busy  out  1  state≠IDLE or FIFO non-empty

Behaviour:
- Reset (async, rst_n=0): FSM→IDLE, FIFO flushed, counters 0. All outputs 0 except req_ready=1 (FIFO empty). Reset mid-job aborts it silently; the core shares rst_n.
- FIFO push on req_valid&&req_ready. req_ready is purely !full, so a push while full is refused even if a pop occurs in the same cycle. Simultaneous push+pop when not full leaves the count unchanged.
- FSM states:
  - IDLE: if FIFO non-empty, pop into job register → ISSUE; otherwise stay.
  - ISSUE: core_in_valid=1 for exactly this cycle; watchdog cleared → WAIT.
  - WAIT: watchdog +1 per cycle.
    - core_out_valid=1: capture core_rx/core_ry into rsp_rx/rsp_ry, rsp_err=0 → RESP.
    - Otherwise, if watchdog==TIMEOUT_CYCLES-1: rsp_rx=rsp_ry=0, rsp_err=1 → RESP.
    - core_out_valid takes priority when both conditions occur in the same cycle.
  - RESP: rsp_valid=1; rsp_* held stable until rsp_valid&&rsp_ready → IDLE.
- core_px/py/k are driven from the job register in every state and never X. They hold the last job's operands; value 0 after reset.
- core_out_valid outside WAIT (late, after a timeout) is ignored.
- Latency (empty FIFO, IDLE): request accepted at edge t → core_in_valid high in the cycle after edge t+1.
  - rsp_valid rises in the cycle after the edge that samples core_out_valid.
  - On timeout, rsp_valid rises TIMEOUT_CYCLES+1 cycles after the core_in_valid cycle.
- Minimum gap between consecutive core_in_valid pulses: ISSUE, WAIT(≥1), RESP(≥1), IDLE.
- rsp_tag equals the tag of the issued job, so responses come back in order.

Optional Feature:
- Macro ECC_PM_LATENCY_CNT_EN.
- Defined: adds output port rsp_cycles [CNT_W-1:0], holding the number of WAIT cycles for the job (watchdog value at capture, +1). It is valid with rsp_valid and is TIMEOUT_CYCLES on error.
- Undefined: the port and its register are absent, and behaviour is otherwise identical.

Test Plan:
- Bench core model: latency L, returns Rx=Px+k, Ry=Py+k.
- Single job, L=20: Px=1, Py=2, k=3, tag=5 → one core_in_valid pulse 2 cycles after accept with operands 1/2/3; rsp_valid the cycle after core_out_valid with rx=4, ry=5, tag=5, err=0; rsp_cycles=20 when the macro is defined.
- Fill, L=50, tags 0..5 pushed back-to-back: tag0 issued; tags 1–4 queued; req_ready=0 after tag4 accepted, so tag5 is held off. Responses return in tag order 0..5, each err=0.
- Timeout, TIMEOUT_CYCLES=100, core silent: rsp_valid 101 cycles after core_in_valid with err=1, rx=ry=0. A core_out_valid injected 5 cycles later is ignored and produces no extra response.
- Backpressure: rsp_ready=0 for 10 cycles with 2 jobs queued → rsp_* stable, no core_in_valid. The next issue comes only after the handshake.
- Reset mid-WAIT with 3 jobs queued: assert rst_n=0 → all outputs 0 and req_ready=1 immediately. After release, no core_in_valid and busy=0 until a new request arrives.

Source files
------------

// File: rtl/ecc_pm_job_sequencer.sv
`default_nettype none
// ============================================================================
// ecc_pm_job_sequencer : request FIFO + one-at-a-time issue/wait/respond front-end
// for the ECC k*P core, with watchdog. Optional macro ECC_PM_LATENCY_CNT_EN adds
// rsp_cycles. Revision 1.0
// ============================================================================
module ecc_pm_job_sequencer #(
    parameter int DATA_WIDTH     = 256,
    parameter int DEPTH          = 4,
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_px,
    input  logic [DATA_WIDTH-1:0] req_py,
    input  logic [DATA_WIDTH-1:0] req_k,
    input  logic [TAG_W-1:0]      req_tag,
    output logic                  core_in_valid,
    output logic [DATA_WIDTH-1:0] core_px,
    output logic [DATA_WIDTH-1:0] core_py,
    output logic [DATA_WIDTH-1:0] core_k,
    input  logic [DATA_WIDTH-1:0] core_rx,
    input  logic [DATA_WIDTH-1:0] core_ry,
    input  logic                  core_out_valid,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rx,
    output logic [DATA_WIDTH-1:0] rsp_ry,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic                  rsp_err,
    output logic                  busy
`ifdef ECC_PM_LATENCY_CNT_EN
    ,
    output logic [CNT_W-1:0]      rsp_cycles
`endif
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_BW  = PTR_W + 1;
    localparam int ENTRY_W = 3 * DATA_WIDTH + TAG_W;
    localparam logic [CNT_BW-1:0] C_FULL    = CNT_BW'(DEPTH);
    localparam logic [CNT_W-1:0]  C_WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ENTRY_W-1:0]    fifo_mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_BW-1:0]     count_q, count_d;
    logic [ENTRY_W-1:0]    job_q, job_d;
    logic [CNT_W-1:0]      wd_q, wd_d;
    logic                  core_in_valid_q, core_in_valid_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rx_q, rsp_rx_d;
    logic [DATA_WIDTH-1:0] rsp_ry_q, rsp_ry_d;
    logic [TAG_W-1:0]      rsp_tag_q, rsp_tag_d;
`ifdef ECC_PM_LATENCY_CNT_EN
    logic [CNT_W-1:0]      rsp_cycles_q, rsp_cycles_d;
`endif

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    assign fifo_full  = (count_q == C_FULL);
    assign fifo_empty = (count_q == '0);
    // Ready depends only on fullness; a same-cycle pop never frees a slot for a push.
    assign push = req_valid && !fifo_full;
    assign pop  = (state_q == S_IDLE) && !fifo_empty;

    // Storage needs no reset: entries are only read once the pointers say they were written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {req_px, req_py, req_k, req_tag};
        end
    end

    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        job_d           = job_q;
        wd_d            = wd_q;
        core_in_valid_d = 1'b0;
        rsp_valid_d     = rsp_valid_q;
        rsp_err_d       = rsp_err_q;
        rsp_rx_d        = rsp_rx_q;
        rsp_ry_d        = rsp_ry_q;
        rsp_tag_d       = rsp_tag_q;
`ifdef ECC_PM_LATENCY_CNT_EN
        rsp_cycles_d    = rsp_cycles_q;
`endif

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_BW'(1);
            2'b01:   count_d = count_q - CNT_BW'(1);
            default: count_d = count_q;
        endcase

        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    job_d           = fifo_mem[rd_ptr_q];
                    core_in_valid_d = 1'b1;
                    state_d         = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + CNT_W'(1);
                // A result arriving on the last watchdog cycle still wins over the timeout.
                if (core_out_valid) begin
                    rsp_rx_d    = core_rx;
                    rsp_ry_d    = core_ry;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_tag_d   = job_q[TAG_W-1:0];
`ifdef ECC_PM_LATENCY_CNT_EN
                    rsp_cycles_d = wd_q + CNT_W'(1);
`endif
                    state_d     = S_RESP;
                end else if (wd_q == C_WD_LAST) begin
                    rsp_rx_d    = '0;
                    rsp_ry_d    = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_tag_d   = job_q[TAG_W-1:0];
`ifdef ECC_PM_LATENCY_CNT_EN
                    rsp_cycles_d = wd_q + CNT_W'(1);
`endif
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            job_q           <= '0;
            wd_q            <= '0;
            core_in_valid_q <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_err_q       <= 1'b0;
            rsp_rx_q        <= '0;
            rsp_ry_q        <= '0;
            rsp_tag_q       <= '0;
`ifdef ECC_PM_LATENCY_CNT_EN
            rsp_cycles_q    <= '0;
`endif
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            job_q           <= job_d;
            wd_q            <= wd_d;
            core_in_valid_q <= core_in_valid_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_err_q       <= rsp_err_d;
            rsp_rx_q        <= rsp_rx_d;
            rsp_ry_q        <= rsp_ry_d;
            rsp_tag_q       <= rsp_tag_d;
`ifdef ECC_PM_LATENCY_CNT_EN
            rsp_cycles_q    <= rsp_cycles_d;
`endif
        end
    end

    assign req_ready     = !fifo_full;
    assign core_in_valid = core_in_valid_q;
    assign core_px       = job_q[ENTRY_W-1 -: DATA_WIDTH];
    assign core_py       = job_q[TAG_W+2*DATA_WIDTH-1 -: DATA_WIDTH];
    assign core_k        = job_q[TAG_W+DATA_WIDTH-1 -: DATA_WIDTH];
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rx        = rsp_rx_q;
    assign rsp_ry        = rsp_ry_q;
    assign rsp_tag       = rsp_tag_q;
    assign rsp_err       = rsp_err_q;
    assign busy          = (state_q != S_IDLE) || !fifo_empty;
`ifdef ECC_PM_LATENCY_CNT_EN
    assign rsp_cycles    = rsp_cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ecc_pm_job_sequencer.sv
`default_nettype none
// Randomized self-checking bench for ecc_pm_job_sequencer: queue-based job model,
// bench-side core model (Rx=Px+k, Ry=Py+k after L cycles), directed scenarios.
module tb_ecc_pm_job_sequencer;

    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int TW    = 4;
    localparam int TO    = 100;
    localparam int CW    = 32;

    typedef struct packed {
        logic [DW-1:0] px;
        logic [DW-1:0] py;
        logic [DW-1:0] k;
        logic [TW-1:0] tag;
    } job_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] req_px = '0, req_py = '0, req_k = '0;
    logic [TW-1:0] req_tag = '0;
    logic          core_in_valid;
    logic [DW-1:0] core_px, core_py, core_k;
    logic [DW-1:0] core_rx = '0, core_ry = '0;
    logic          core_out_valid = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rx, rsp_ry;
    logic [TW-1:0] rsp_tag;
    logic          rsp_err;
    logic          busy;
`ifdef ECC_PM_LATENCY_CNT_EN
    logic [CW-1:0] rsp_cycles;
`endif

    ecc_pm_job_sequencer #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .TAG_W(TW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_px(req_px), .req_py(req_py), .req_k(req_k), .req_tag(req_tag),
        .core_in_valid(core_in_valid),
        .core_px(core_px), .core_py(core_py), .core_k(core_k),
        .core_rx(core_rx), .core_ry(core_ry), .core_out_valid(core_out_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rx(rsp_rx), .rsp_ry(rsp_ry), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .busy(busy)
`ifdef ECC_PM_LATENCY_CNT_EN
        , .rsp_cycles(rsp_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // scenario controls (written by the main sequence)
    job_t to_send[$];
    int   valid_prob = 100;
    int   rdy_prob   = 100;
    int   core_lat   = 20;
    bit   core_rand  = 1'b0;
    bit   noise_en   = 1'b0;
    bit   inject_ov  = 1'b0;

    // observations of the DUT
    int            cyc = 0, acc_cyc = 0, issue_cyc = 0, rise_cyc = 0;
    int            issue_cnt = 0, rsp_cnt = 0, refused = 0;
    logic [DW-1:0] rise_rx, rise_ry;
    logic [TW-1:0] rise_tag;
    logic          rise_err;
    logic [CW-1:0] rise_cycles = '0;
    logic [TW-1:0] rsp_tags[$];
    bit            prev_rv = 1'b0;

    // behavioural model: queued jobs, current job and where it is in its life
    job_t          mq[$];
    job_t          cur = '0;
    bit            m_issue = 1'b0, m_wait = 1'b0, m_resp = 1'b0;
    int            m_e = 0;
    logic [DW-1:0] e_rx = '0, e_ry = '0;
    bit            e_err = 1'b0;
    int            e_cyc = 0;
    bit            push;

    // core model
    int            cd = 0;
    logic [DW-1:0] c_rx = '0, c_ry = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic job_t mk(input logic [DW-1:0] px, input logic [DW-1:0] py,
                                input logic [DW-1:0] k, input logic [TW-1:0] tag);
        job_t j;
        j.px = px; j.py = py; j.k = k; j.tag = tag;
        return j;
    endfunction

    function automatic job_t rnd_job();
        return mk({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                  TW'($urandom_range(0, 15)));
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Per-cycle compare, stimulus drive and model step, all at the falling edge.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("rst req_ready", req_ready, 1);
            chk("rst busy", busy, 0);
            chk("rst core_in_valid", core_in_valid, 0);
            chk("rst rsp_valid", rsp_valid, 0);
            chk("rst core_px", core_px, 0);
            chk("rst rsp_rx", rsp_rx, 0);
            mq.delete();
            cur = '0; m_issue = 0; m_wait = 0; m_resp = 0;
            cd = 0; prev_rv = 0;
            req_valid = 0; core_out_valid = 0; inject_ov = 0;
        end else begin
            cyc++;
            chk("req_ready", req_ready, mq.size() < DEPTH);
            chk("busy", busy, m_issue || m_wait || m_resp || mq.size() != 0);
            chk("core_in_valid", core_in_valid, m_issue);
            chk("core_px", core_px, cur.px);
            chk("core_py", core_py, cur.py);
            chk("core_k", core_k, cur.k);
            chk("rsp_valid", rsp_valid, m_resp);
            if (m_resp) begin
                chk("rsp_rx", rsp_rx, e_rx);
                chk("rsp_ry", rsp_ry, e_ry);
                chk("rsp_tag", rsp_tag, cur.tag);
                chk("rsp_err", rsp_err, e_err);
`ifdef ECC_PM_LATENCY_CNT_EN
                chk("rsp_cycles", rsp_cycles, e_cyc);
`endif
            end

            if (core_in_valid) begin
                issue_cyc = cyc;
                issue_cnt++;
                c_rx = core_px + core_k;
                c_ry = core_py + core_k;
            end
            if (rsp_valid && !prev_rv) begin
                rise_cyc = cyc; rise_rx = rsp_rx; rise_ry = rsp_ry;
                rise_tag = rsp_tag; rise_err = rsp_err;
`ifdef ECC_PM_LATENCY_CNT_EN
                rise_cycles = rsp_cycles;
`endif
            end
            prev_rv = rsp_valid;

            // drive inputs sampled at the coming rising edge
            if (to_send.size() > 0 && (req_valid || int'($urandom % 100) < valid_prob)) begin
                req_valid = 1; req_px = to_send[0].px; req_py = to_send[0].py;
                req_k = to_send[0].k; req_tag = to_send[0].tag;
            end else begin
                req_valid = 0;
            end
            rsp_ready = int'($urandom % 100) < rdy_prob;
            core_out_valid = 0;
            core_rx = {$urandom, $urandom};
            core_ry = {$urandom, $urandom};
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    core_out_valid = 1; core_rx = c_rx; core_ry = c_ry;
                end
            end else if (noise_en && ($urandom % 100) < 2) begin
                core_out_valid = 1;
            end
            if (inject_ov) begin
                core_out_valid = 1;
                inject_ov = 0;
            end
            if (core_in_valid) cd = core_rand ? int'($urandom_range(1, 110)) : core_lat;

            if (rsp_valid && rsp_ready) begin
                rsp_cnt++;
                rsp_tags.push_back(rsp_tag);
            end
            if (req_valid && !req_ready) refused++;

            // model step: what the next cycle must look like
            push = req_valid && (mq.size() < DEPTH);
            if (m_issue) begin
                m_issue = 0; m_wait = 1; m_e = 1;
            end else if (m_wait) begin
                if (core_out_valid) begin
                    m_wait = 0; m_resp = 1; e_rx = core_rx; e_ry = core_ry; e_err = 0; e_cyc = m_e;
                end else if (m_e == TO) begin
                    m_wait = 0; m_resp = 1; e_rx = '0; e_ry = '0; e_err = 1; e_cyc = TO;
                end else begin
                    m_e++;
                end
            end else if (m_resp) begin
                if (rsp_ready) m_resp = 0;
            end else if (mq.size() > 0) begin
                cur = mq.pop_front();
                m_issue = 1;
            end
            if (push) begin
                mq.push_back(mk(req_px, req_py, req_k, req_tag));
                acc_cyc = cyc;
                void'(to_send.pop_front());
            end
        end
    end

    task automatic wait_rsp(input int n, input int budget, input string nm);
        int b = 0;
        while (rsp_cnt < n && b < budget) begin
            tick();
            b++;
        end
        chk({nm, " responses arrived"}, rsp_cnt >= n, 1);
    endtask

    initial begin
        int n0, ic, base, b;
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        repeat (2) tick();

        // single job, L=20
        core_lat = 20;
        to_send.push_back(mk(1, 2, 3, 5));
        wait_rsp(1, 200, "single");
        chk("single issue latency", issue_cyc - acc_cyc, 2);
        chk("single rsp latency", rise_cyc - issue_cyc, 21);
        chk("single rx", rise_rx, 4);
        chk("single ry", rise_ry, 5);
        chk("single tag", rise_tag, 5);
        chk("single err", rise_err, 0);
`ifdef ECC_PM_LATENCY_CNT_EN
        chk("single cycles", rise_cycles, 20);
`endif

        // fill the FIFO, L=50, tags 0..5
        core_lat = 50; refused = 0; n0 = rsp_cnt; base = rsp_tags.size();
        for (int t = 0; t < 6; t++) to_send.push_back(mk({$urandom, $urandom}, 7, 9, TW'(t)));
        wait_rsp(n0 + 6, 1500, "fill");
        chk("fill tag5 held off", refused > 0, 1);
        for (int i = 0; i < 6; i++) begin
            if (base + i < rsp_tags.size()) chk("fill tag order", rsp_tags[base + i], i);
            else chk("fill tag present", 0, 1);
        end

        // timeout with silent core, then a late out_valid
        core_lat = 0; n0 = rsp_cnt;
        to_send.push_back(mk(11, 12, 13, 3));
        wait_rsp(n0 + 1, 400, "timeout");
        chk("timeout latency", rise_cyc - issue_cyc, 101);
        chk("timeout err", rise_err, 1);
        chk("timeout rx", rise_rx, 0);
        chk("timeout ry", rise_ry, 0);
`ifdef ECC_PM_LATENCY_CNT_EN
        chk("timeout cycles", rise_cycles, TO);
`endif
        n0 = rsp_cnt; ic = issue_cnt;
        repeat (4) tick();
        inject_ov = 1;
        repeat (20) tick();
        chk("late ov no response", rsp_cnt, n0);
        chk("late ov no issue", issue_cnt, ic);

        // result on the very last watchdog cycle beats the timeout
        core_lat = TO; n0 = rsp_cnt;
        to_send.push_back(mk(10, 20, 7, 9));
        wait_rsp(n0 + 1, 400, "edge");
        chk("edge latency", rise_cyc - issue_cyc, 101);
        chk("edge err", rise_err, 0);
        chk("edge rx", rise_rx, 17);
        chk("edge ry", rise_ry, 27);
`ifdef ECC_PM_LATENCY_CNT_EN
        chk("edge cycles", rise_cycles, TO);
`endif

        // response backpressure with two jobs queued behind
        core_lat = 5; rdy_prob = 0; n0 = rsp_cnt;
        for (int i = 0; i < 3; i++) to_send.push_back(rnd_job());
        b = 0;
        while (!rsp_valid && b < 100) begin tick(); b++; end
        chk("bp response pending", rsp_valid, 1);
        ic = issue_cnt;
        repeat (10) tick();
        chk("bp no issue while stalled", issue_cnt, ic);
        chk("bp still valid", rsp_valid, 1);
        rdy_prob = 100;
        wait_rsp(n0 + 3, 200, "bp");
        chk("bp remaining issues", issue_cnt, ic + 2);

        // reset during WAIT with three jobs queued
        core_lat = 0;
        for (int i = 0; i < 4; i++) to_send.push_back(rnd_job());
        repeat (15) tick();
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("mid rst req_ready", req_ready, 1);
        chk("mid rst busy", busy, 0);
        chk("mid rst core_in_valid", core_in_valid, 0);
        chk("mid rst rsp_valid", rsp_valid, 0);
        chk("mid rst core_px", core_px, 0);
        chk("mid rst core_py", core_py, 0);
        chk("mid rst core_k", core_k, 0);
        chk("mid rst rsp_rx", rsp_rx, 0);
        chk("mid rst rsp_ry", rsp_ry, 0);
        chk("mid rst rsp_tag", rsp_tag, 0);
        chk("mid rst rsp_err", rsp_err, 0);
`ifdef ECC_PM_LATENCY_CNT_EN
        chk("mid rst rsp_cycles", rsp_cycles, 0);
`endif
        to_send.delete();
        repeat (2) tick();
        @(posedge clk);
        #2 rst_n = 1;
        ic = issue_cnt;
        repeat (20) tick();
        chk("post rst no issue", issue_cnt, ic);
        chk("post rst idle", busy, 0);
        core_lat = 8; n0 = rsp_cnt;
        to_send.push_back(mk(100, 200, 1, 6));
        wait_rsp(n0 + 1, 100, "post rst job");
        chk("post rst rx", rise_rx, 101);

        // randomized traffic
        core_rand = 1; noise_en = 1; rdy_prob = 70; valid_prob = 60; n0 = rsp_cnt;
        for (int i = 0; i < 120; i++) to_send.push_back(rnd_job());
        wait_rsp(n0 + 120, 30000, "random");
        noise_en = 0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
